// File: rtl/fir_pkg.sv
// Shared definitions for the transposed-form FIR: FSM encoding, default widths,
// and the saturation / tap-count clamp helpers.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } firState_t;

  localparam int unsigned DEF_NUM_TAPS  = 33;
  localparam int unsigned DEF_DIN_W     = 3;
  localparam int unsigned DEF_COEF_W    = 16;
  localparam int unsigned DEF_DOUT_W    = 16;
  localparam int unsigned DEF_ACC_W     = 26;
  localparam int unsigned DEF_OUT_SHIFT = 0;
  localparam int unsigned DEF_ADDR_W    = 6;

  // Saturation works on a wide signed container so one function serves any ACC_W.
  localparam int unsigned SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] acc,
    input int unsigned             shift,
    input int unsigned             outW
  );
    logic signed [SAT_W-1:0] sh;
    logic signed [SAT_W-1:0] maxV;
    logic signed [SAT_W-1:0] minV;
    sh   = acc >>> shift;
    maxV = (SAT_W'(64'sd1) <<< (outW - 1)) - SAT_W'(64'sd1);
    minV = -maxV - SAT_W'(64'sd1);
    if (sh > maxV)      return maxV;
    else if (sh < minV) return minV;
    else                return sh;
  endfunction

  function automatic int unsigned clampTaps(
    input int unsigned n,
    input int unsigned maxTaps
  );
    if (n < 1)            return 1;
    else if (n > maxTaps) return maxTaps;
    else                  return n;
  endfunction

endpackage

// File: rtl/fir_tap_cell.sv
// One transposed-form tap: sOut <= x*c + sIn when enabled, cleared on clr.
module fir_tap_cell #(
  parameter int unsigned DIN_W  = 3,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned ACC_W  = 26
) (
  input  logic                     clk,
  input  logic                     rsn,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DIN_W-1:0]  x,
  input  logic signed [COEF_W-1:0] c,
  input  logic signed [ACC_W-1:0]  sIn,
  output logic signed [ACC_W-1:0]  sOut
);

  logic signed [ACC_W-1:0] xExt;
  logic signed [ACC_W-1:0] cExt;

  assign xExt = {{(ACC_W-DIN_W){x[DIN_W-1]}}, x};
  assign cExt = {{(ACC_W-COEF_W){c[COEF_W-1]}}, c};

  always_ff @(posedge clk) begin
    if (!rsn)     sOut <= '0;
    else if (clr) sOut <= '0;
    else if (en)  sOut <= xExt * cExt + sIn;
  end

endmodule

// File: rtl/param_trans_fir.sv
// Parametrised transposed-form FIR with shadow/active coefficient banks,
// runtime tap count, valid qualification and saturated output.
module param_trans_fir
  import fir_pkg::*;
#(
  parameter int unsigned NUM_TAPS  = 33,
  parameter int unsigned DIN_W     = 3,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned DOUT_W    = 16,
  parameter int unsigned ACC_W     = 26,
  parameter int unsigned OUT_SHIFT = 0,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic                     iClk_12M,
  input  logic                     iRsn,
  input  logic                     iCoeffUpdateFlag,
  input  logic                     iCoeffWrEn,
  input  logic [ADDR_W-1:0]        iCoeffAddr,
  input  logic signed [COEF_W-1:0] iCoeffData,
  input  logic                     iCoeffCommit,
  input  logic [ADDR_W:0]          iNumOfCoeff,
  input  logic                     iFirValid,
  input  logic signed [DIN_W-1:0]  iFirIn,
  output logic                     oFirValid,
  output logic signed [DOUT_W-1:0] oFirOut,
  output logic                     oLoadMode,
  output logic                     oCoeffErr
);

  firState_t state, nextState;

  logic commit;
  logic wrAccept;
  logic wrReject;
  logic shiftEn;
  logic loadModeD;

  logic signed [COEF_W-1:0] shadow     [NUM_TAPS];
  logic signed [COEF_W-1:0] shadowNext [NUM_TAPS];
  logic signed [COEF_W-1:0] active     [NUM_TAPS];
  logic signed [COEF_W-1:0] cEff       [NUM_TAPS];
  logic [ADDR_W:0]          tapCnt;

  logic signed [ACC_W-1:0]  sChain [1:NUM_TAPS];
  logic signed [ACC_W-1:0]  xExt;
  logic signed [ACC_W-1:0]  c0Ext;
  logic signed [ACC_W-1:0]  acc0;
  logic signed [SAT_W-1:0]  satOut;

  always_ff @(posedge iClk_12M) begin
    if (!iRsn) state <= IDLE;
    else       state <= nextState;
  end

  // Commit takes priority over a simultaneous update request while in LOAD.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (iCoeffUpdateFlag) nextState = LOAD;
      LOAD:    if (iCoeffCommit)     nextState = RUN;
      RUN:     if (iCoeffUpdateFlag) nextState = LOAD;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    commit    = (state == LOAD) && iCoeffCommit;
    wrAccept  = (state == LOAD) && iCoeffWrEn && (32'(iCoeffAddr) < NUM_TAPS);
    wrReject  = (state == LOAD) && iCoeffWrEn && (32'(iCoeffAddr) >= NUM_TAPS);
    shiftEn   = iFirValid && !commit;
    loadModeD = (nextState == LOAD);
  end

  // Shadow contents after this cycle's write, so a same-cycle commit copies it.
  always_comb begin
    shadowNext = shadow;
    for (int unsigned k = 0; k < NUM_TAPS; k++) begin
      if (wrAccept && (32'(iCoeffAddr) == k)) shadowNext[k] = iCoeffData;
    end
  end

  always_ff @(posedge iClk_12M) begin
    if (!iRsn) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      tapCnt    <= (ADDR_W+1)'(NUM_TAPS);
      oCoeffErr <= 1'b0;
      oLoadMode <= 1'b0;
    end else begin
      shadow    <= shadowNext;
      oLoadMode <= loadModeD;
      if (wrReject) oCoeffErr <= 1'b1;
      if (commit) begin
        active <= shadowNext;
        tapCnt <= (ADDR_W+1)'(clampTaps(32'(iNumOfCoeff), NUM_TAPS));
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_TAPS; k++) begin
      cEff[k] = (k < 32'(tapCnt)) ? active[k] : '0;
    end
  end

  assign sChain[NUM_TAPS] = '0;

  for (genvar k = 1; k < NUM_TAPS; k++) begin : gTap
    fir_tap_cell #(
      .DIN_W (DIN_W),
      .COEF_W(COEF_W),
      .ACC_W (ACC_W)
    ) uCell (
      .clk (iClk_12M),
      .rsn (iRsn),
      .en  (shiftEn),
      .clr (commit),
      .x   (iFirIn),
      .c   (cEff[k]),
      .sIn (sChain[k+1]),
      .sOut(sChain[k])
    );
  end

  assign xExt   = {{(ACC_W-DIN_W){iFirIn[DIN_W-1]}}, iFirIn};
  assign c0Ext  = {{(ACC_W-COEF_W){cEff[0][COEF_W-1]}}, cEff[0]};
  assign acc0   = xExt * c0Ext + sChain[1];
  assign satOut = saturate({{(SAT_W-ACC_W){acc0[ACC_W-1]}}, acc0}, OUT_SHIFT, DOUT_W);

  always_ff @(posedge iClk_12M) begin
    if (!iRsn) begin
      oFirOut   <= '0;
      oFirValid <= 1'b0;
    end else if (commit) begin
      oFirValid <= 1'b0;
    end else if (iFirValid) begin
      oFirOut   <= satOut[DOUT_W-1:0];
      oFirValid <= 1'b1;
    end else begin
      oFirValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_trans_fir.sv
// Directed self-checking bench for param_trans_fir at default parameters.
module tb_param_trans_fir;

  logic               clk = 1'b0;
  logic               rsn;
  logic               updFlag;
  logic               wrEn;
  logic [5:0]         addr;
  logic signed [15:0] data;
  logic               commitIn;
  logic [6:0]         numCoeff;
  logic               firValidIn;
  logic signed [2:0]  firIn;
  logic               firValid;
  logic signed [15:0] firOut;
  logic               loadMode;
  logic               coeffErr;

  int total = 0;
  int bad   = 0;

  param_trans_fir #(
    .NUM_TAPS (33),
    .DIN_W    (3),
    .COEF_W   (16),
    .DOUT_W   (16),
    .ACC_W    (26),
    .OUT_SHIFT(0),
    .ADDR_W   (6)
  ) dut (
    .iClk_12M        (clk),
    .iRsn            (rsn),
    .iCoeffUpdateFlag(updFlag),
    .iCoeffWrEn      (wrEn),
    .iCoeffAddr      (addr),
    .iCoeffData      (data),
    .iCoeffCommit    (commitIn),
    .iNumOfCoeff     (numCoeff),
    .iFirValid       (firValidIn),
    .iFirIn          (firIn),
    .oFirValid       (firValid),
    .oFirOut         (firOut),
    .oLoadMode       (loadMode),
    .oCoeffErr       (coeffErr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rsn = 1'b0;
    tick();
    tick();
    rsn = 1'b1;
  endtask

  task automatic enterLoad();
    updFlag = 1'b1;
    tick();
    updFlag = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    wrEn = 1'b1;
    addr = 6'(a);
    data = 16'(d);
    tick();
    wrEn = 1'b0;
  endtask

  task automatic doCommit(input int n);
    commitIn = 1'b1;
    numCoeff = 7'(n);
    tick();
    commitIn = 1'b0;
  endtask

  task automatic load123();
    enterLoad();
    wr(0, 1);
    wr(1, 2);
    wr(2, 3);
    doCommit(3);
  endtask

  task automatic sample(input int x);
    firValidIn = 1'b1;
    firIn      = 3'(x);
    tick();
    firValidIn = 1'b0;
    firIn      = '0;
  endtask

  task automatic test_reset();
    doReset();
    total++;
    if (firOut !== 16'sd0 || firValid !== 1'b0 || loadMode !== 1'b0 || coeffErr !== 1'b0) begin
      bad++;
      $display("FAIL reset: out=%0d valid=%b load=%b err=%b, want 0 0 0 0", firOut, firValid, loadMode, coeffErr);
    end
    sample(1);
    total++;
    if (firOut !== 16'sd0 || firValid !== 1'b1) begin
      bad++;
      $display("FAIL reset_zero_coef: out=%0d valid=%b, want 0 1", firOut, firValid);
    end
  endtask

  task automatic test_impulse();
    int exp[5] = '{1, 2, 3, 0, 0};
    doReset();
    enterLoad();
    total++;
    if (loadMode !== 1'b1) begin
      bad++;
      $display("FAIL load_mode: got %b want 1", loadMode);
    end
    wr(0, 1);
    wr(1, 2);
    wr(2, 3);
    doCommit(3);
    total++;
    if (loadMode !== 1'b0 || firValid !== 1'b0) begin
      bad++;
      $display("FAIL after_commit: load=%b valid=%b want 0 0", loadMode, firValid);
    end
    for (int i = 0; i < 5; i++) begin
      sample(i == 0 ? 1 : 0);
      total++;
      if (firOut !== 16'(exp[i]) || firValid !== 1'b1) begin
        bad++;
        $display("FAIL impulse[%0d]: out=%0d valid=%b want %0d 1", i, firOut, firValid, exp[i]);
      end
    end
    tick();
    total++;
    if (firValid !== 1'b0 || firOut !== 16'sd0) begin
      bad++;
      $display("FAIL idle_hold: valid=%b out=%0d want 0 0", firValid, firOut);
    end
  endtask

  task automatic test_saturation();
    doReset();
    enterLoad();
    for (int a = 0; a < 33; a++) wr(a, 32767);
    doCommit(33);
    for (int i = 0; i < 5; i++) begin
      sample(3);
      total++;
      if (firOut !== 16'sh7FFF) begin
        bad++;
        $display("FAIL sat_pos[%0d]: out=%0d want 32767", i, firOut);
      end
    end
    sample(-4);
    total++;
    if (firOut !== 16'sh7FFF) begin
      bad++;
      $display("FAIL sat_history: out=%0d want 32767", firOut);
    end
    for (int i = 0; i < 40; i++) sample(-4);
    total++;
    if (firOut !== 16'sh8000 || firValid !== 1'b1) begin
      bad++;
      $display("FAIL sat_neg: out=%0d valid=%b want -32768 1", firOut, firValid);
    end
  endtask

  task automatic test_shadow();
    int expA[4] = '{1, 2, 3, 0};
    int expB[4] = '{5, 7, 3, 0};
    doReset();
    load123();
    for (int i = 0; i < 4; i++) sample(i == 0 ? 1 : 0);
    enterLoad();
    wr(0, 5);
    for (int i = 0; i < 4; i++) begin
      sample(i == 0 ? 1 : 0);
      total++;
      if (firOut !== 16'(expA[i])) begin
        bad++;
        $display("FAIL shadow_isolated[%0d]: out=%0d want %0d", i, firOut, expA[i]);
      end
    end
    wrEn     = 1'b1;
    addr     = 6'd1;
    data     = 16'sd7;
    commitIn = 1'b1;
    numCoeff = 7'd3;
    tick();
    wrEn     = 1'b0;
    commitIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample(i == 0 ? 1 : 0);
      total++;
      if (firOut !== 16'(expB[i])) begin
        bad++;
        $display("FAIL write_with_commit[%0d]: out=%0d want %0d", i, firOut, expB[i]);
      end
    end
  endtask

  task automatic test_addr_err();
    int exp[4] = '{1, 2, 3, 0};
    doReset();
    enterLoad();
    wr(0, 1);
    wr(1, 2);
    wr(2, 3);
    wr(32, 0);
    total++;
    if (coeffErr !== 1'b0) begin
      bad++;
      $display("FAIL err_last_valid: err=%b want 0", coeffErr);
    end
    wr(33, 9);
    total++;
    if (coeffErr !== 1'b1) begin
      bad++;
      $display("FAIL err_boundary: err=%b want 1", coeffErr);
    end
    wr(40, 9);
    doCommit(33);
    for (int i = 0; i < 4; i++) begin
      sample(i == 0 ? 1 : 0);
      total++;
      if (firOut !== 16'(exp[i]) || coeffErr !== 1'b1) begin
        bad++;
        $display("FAIL err_shadow[%0d]: out=%0d err=%b want %0d 1", i, firOut, coeffErr, exp[i]);
      end
    end
    doReset();
    total++;
    if (coeffErr !== 1'b0) begin
      bad++;
      $display("FAIL err_reset: err=%b want 0", coeffErr);
    end
  endtask

  task automatic test_clamp();
    doReset();
    enterLoad();
    wr(0, 1);
    wr(1, 2);
    wr(32, 4);
    doCommit(0);
    sample(1);
    sample(0);
    total++;
    if (firOut !== 16'sd0) begin
      bad++;
      $display("FAIL clamp_low: out=%0d want 0", firOut);
    end
    enterLoad();
    doCommit(100);
    for (int i = 0; i < 33; i++) sample(i == 0 ? 1 : 0);
    total++;
    if (firOut !== 16'sd4) begin
      bad++;
      $display("FAIL clamp_high: out=%0d want 4", firOut);
    end
  endtask

  task automatic test_commit_midstream();
    int exp[4] = '{1, 3, 6, 6};
    doReset();
    load123();
    for (int i = 0; i < 4; i++) sample(1);
    updFlag = 1'b1;
    sample(1);
    updFlag = 1'b0;
    total++;
    if (loadMode !== 1'b1 || firOut !== 16'sd6) begin
      bad++;
      $display("FAIL stream_load: load=%b out=%0d want 1 6", loadMode, firOut);
    end
    firValidIn = 1'b1;
    firIn      = 3'sd1;
    commitIn   = 1'b1;
    updFlag    = 1'b1;
    numCoeff   = 7'd3;
    tick();
    commitIn   = 1'b0;
    updFlag    = 1'b0;
    total++;
    if (firValid !== 1'b0 || loadMode !== 1'b0) begin
      bad++;
      $display("FAIL commit_cycle: valid=%b load=%b want 0 0", firValid, loadMode);
    end
    for (int i = 0; i < 4; i++) begin
      sample(1);
      total++;
      if (firOut !== 16'(exp[i]) || firValid !== 1'b1) begin
        bad++;
        $display("FAIL refill[%0d]: out=%0d valid=%b want %0d 1", i, firOut, firValid, exp[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    doReset();
    load123();
    for (int i = 0; i < 4; i++) sample(1);
    firValidIn = 1'b1;
    firIn      = 3'sd1;
    rsn        = 1'b0;
    tick();
    rsn        = 1'b1;
    firValidIn = 1'b0;
    total++;
    if (firOut !== 16'sd0 || firValid !== 1'b0 || loadMode !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: out=%0d valid=%b load=%b want 0 0 0", firOut, firValid, loadMode);
    end
    for (int i = 0; i < 3; i++) begin
      sample(1);
      total++;
      if (firOut !== 16'sd0) begin
        bad++;
        $display("FAIL rst_zero[%0d]: out=%0d want 0", i, firOut);
      end
    end
    wr(0, 5);
    enterLoad();
    doCommit(1);
    sample(1);
    total++;
    if (firOut !== 16'sd0) begin
      bad++;
      $display("FAIL idle_write_ignored: out=%0d want 0", firOut);
    end
  endtask

  initial begin
    rsn        = 1'b0;
    updFlag    = 1'b0;
    wrEn       = 1'b0;
    addr       = '0;
    data       = '0;
    commitIn   = 1'b0;
    numCoeff   = '0;
    firValidIn = 1'b0;
    firIn      = '0;
    test_reset();
    test_impulse();
    test_saturation();
    test_shadow();
    test_addr_err();
    test_clamp();
    test_commit_midstream();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_trans_fir.md
Name: param_trans_fir

Overview:
Parametrised transposed-form FIR filter. It generalises the fixed 33-tap, 4-RAM filter into a single block with N taps, a double-buffered (shadow/active) coefficient bank, and a runtime tap count. It adds input/output valid qualification and output saturation. It sits between the sample source and the output stage, and its coefficients are loaded over a simple write port from the host controller.

Parameters:
NUM_TAPS, 33, maximum number of taps (2..64)
DIN_W, 3, signed input sample width
COEF_W, 16, signed coefficient width
DOUT_W, 16, signed output width
ACC_W, 26, internal accumulator width (at least DIN_W+COEF_W+clog2(NUM_TAPS))
OUT_SHIFT, 0, arithmetic right shift applied before saturation
ADDR_W, 6, coefficient address width (2^ADDR_W >= NUM_TAPS)

Ports:
iClk_12M  in  1  sole clock, rising edge
iRsn  in  1  synchronous active-low reset
iCoeffUpdateFlag  in  1  request to enter coefficient-load mode
iCoeffWrEn  in  1  coefficient write strobe, valid only in LOAD
iCoeffAddr  in  ADDR_W  tap index 0..NUM_TAPS-1
iCoeffData  in  COEF_W  signed coefficient value
iCoeffCommit  in  1  copy the shadow bank to the active bank, valid only in LOAD
iNumOfCoeff  in  ADDR_W+1  active tap count, sampled on commit
iFirValid  in  1  input sample qualifier
iFirIn  in  DIN_W  signed input sample
oFirValid  out  1  output sample qualifier
oFirOut  out  DOUT_W  signed saturated filter output
oLoadMode  out  1  high while the FSM is in LOAD
oCoeffErr  out  1  sticky: write to an out-of-range address

Behaviour:
- Reset (iRsn=0 at a clock edge): shadow bank, active bank, partial-sum chain, oFirOut, oFirValid, oCoeffErr and oLoadMode all go to 0. Active tap count goes to NUM_TAPS. FSM goes to IDLE. Reset overrides all other inputs, including mid-load and mid-stream.
- FSM states: IDLE, LOAD, RUN.
  - IDLE→LOAD and RUN→LOAD when iCoeffUpdateFlag=1.
  - LOAD→RUN when iCoeffCommit=1.
  - iCoeffCommit is ignored in IDLE and RUN.
  - iCoeffWrEn is ignored outside LOAD.
  - oLoadMode is registered and equals (state==LOAD).
- Filtering runs in every state using the active bank. In IDLE after reset the output is 0 because all coefficients are 0.
- Shadow write: when in LOAD, iCoeffWrEn=1 and iCoeffAddr<NUM_TAPS, then shadow[addr] <= iCoeffData. If addr>=NUM_TAPS, the write is dropped and oCoeffErr <= 1. oCoeffErr clears only on reset.
- Commit:
  - active <= shadow.
  - Tap count T <= clamp(iNumOfCoeff, 1, NUM_TAPS).
  - The partial-sum chain is cleared to 0 at the same edge.
  - oFirValid is forced to 0 for that cycle, even if iFirValid=1; the sample presented that cycle is discarded.
- Simultaneous events:
  - Write and commit in the same LOAD cycle: the write is included in the copy.
  - iCoeffUpdateFlag and iCoeffCommit both high in LOAD: the commit wins, the next state is RUN, and the flag must be re-asserted to re-enter LOAD.
- Effective coefficient: c[k] = active[k] for k<T, 0 otherwise.
- Datapath (only when iFirValid=1 and no commit this cycle):
  - s[k] <= x*c[k] + s[k+1] for k=1..NUM_TAPS-1, with s[NUM_TAPS]=0.
  - acc = x*c[0] + s[1], computed in ACC_W bits, sign-extended.
  - oFirOut <= sat_DOUT_W(acc >>> OUT_SHIFT).
  - oFirValid <= 1.
- When iFirValid=0: the chain holds, oFirOut holds, and oFirValid <= 0.
- Latency: one cycle from valid input to valid output, so y[n]=Σ c[k]·x[n-k] is presented one edge after x[n].
- Saturation: values above 2^(DOUT_W-1)-1 clamp to 0x7FFF; values below -2^(DOUT_W-1) clamp to 0x8000 (both at default width).

Decomposition:
- Shared package fir_pkg holds:
  - FSM state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2);
  - default width constants;
  - a saturate(acc, shift) function;
  - a clamp function for the tap count.
- One sub-module, fir_tap_cell: signed multiply-add-register for one tap. It has enable and clear inputs, takes x, c and s_in, and drives s_out. It is instantiated NUM_TAPS-1 times via generate. The tap-0 adder and saturation stay in the top level.

Test Plan:
1. Load shadow[0..2]={1,2,3}, iNumOfCoeff=3, commit; drive x=1,0,0,0,0 with valid → oFirOut=1,2,3,0,0, oFirValid high each cycle after the first input.
2. Load all 33 taps = 0x7FFF, commit; drive constant x=3 → output saturates at 0x7FFF. Drive constant x=-4 → output 0x8000.
3. Run scenario 1, re-enter LOAD, write tap 0=5 without committing; impulse → still 1,2,3. Then commit with a write to addr 1=7 in the same cycle; impulse → 5,7,3.
4. Write to addr 40 in LOAD → oCoeffErr=1 and stays 1 through a commit; shadow unchanged; reset → oCoeffErr=0.
5. Stream x=1 continuously with {1,2,3}, then commit mid-stream → oFirValid=0 in the commit cycle; next outputs 1,3,6,6 (chain cleared, refilling).
6. Assert iRsn=0 for one edge mid-stream → the next cycle has oFirOut=0, oFirValid=0, FSM in IDLE; subsequent inputs give 0 until coefficients are reloaded.
